cache_arbiter: RTL and testbench

Two-port to one-port arbiter between the split L1 caches and the shared next-level memory (L2 / physical memory). The I-cache (serving the pipeline's fetch port) and the D-cache (serving the memory-stage port) issue 256-bit line fills and writebacks. The arbiter grants exactly one of them at a time, holds the grant until the downstream `m_resp`, and routes data and responses back.

---
 rtl/cache_arbiter_if.sv | 36 +++
 rtl/cache_arbiter.sv | 108 ++++++++++
 tb/tb_cache_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_if.sv
// Bundle of cache-side and memory-side signals for cache_arbiter.
// master: the arbiter's view. slave: the view of the caches and memory model.
interface cache_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  // I-cache side
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  // D-cache side
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  // downstream memory side
  logic              m_read;
  logic              m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  logic [LINE_W-1:0] m_rdata;
  logic              m_resp;

  modport master (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_resp,
    output i_rdata, i_resp, d_rdata, d_resp, m_read, m_write, m_addr, m_wdata
  );

  modport slave (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, m_read, m_write, m_addr, m_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter: grants the I-cache or the D-cache to the shared next-level
// memory, one line transaction at a time, holding the grant until m_resp.
// Optional macro CACHE_ARBITER_RR_EN: round-robin on a tie; otherwise the
// D-cache always wins a tie.
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  cache_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              wr_q;
  logic              last_q;

  logic i_req, d_req, tie_d, cap_i, cap_d;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

`ifdef CACHE_ARBITER_RR_EN
  // Tie goes to the side that was not served last.
  assign tie_d = (last_q == SIDE_I);
`else
  // D always wins a tie; last_q is still tracked but does not steer the grant.
  assign tie_d = 1'b1 | last_q;
`endif

  // Read data is a straight pass-through; each side qualifies it with its resp.
  assign bus.i_rdata = bus.m_rdata;
  assign bus.d_rdata = bus.m_rdata;

  // Downstream address/data always come from the captured request.
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;

  // Next-state, grant and strobe/resp decode.
  always_comb begin
    state_d     = state_q;
    cap_i       = 1'b0;
    cap_d       = 1'b0;
    bus.m_read  = 1'b0;
    bus.m_write = 1'b0;
    bus.i_resp  = 1'b0;
    bus.d_resp  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          cap_d = tie_d;
          cap_i = ~tie_d;
        end else begin
          cap_d = d_req;
          cap_i = i_req;
        end
        if (cap_d)      state_d = SERVE_D;
        else if (cap_i) state_d = SERVE_I;
      end
      SERVE_I: begin
        bus.m_read = 1'b1;
        if (bus.m_resp) begin
          bus.i_resp = 1'b1;
          state_d    = IDLE;
        end
      end
      SERVE_D: begin
        bus.m_read  = ~wr_q;
        bus.m_write = wr_q;
        if (bus.m_resp) begin
          bus.d_resp = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, request capture on grant, and last-served tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      last_q  <= SIDE_D;
    end else begin
      state_q <= state_d;
      if (cap_i) addr_q <= bus.i_addr;
      if (cap_d) begin
        addr_q  <= bus.d_addr;
        wdata_q <= bus.d_wdata;
        // a simultaneous read+write is treated as a write
        wr_q    <= bus.d_write;
      end
      if (state_q == SERVE_I && bus.m_resp) last_q <= SIDE_I;
      if (state_q == SERVE_D && bus.m_resp) last_q <= SIDE_D;
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter; tie expectations follow CACHE_ARBITER_RR_EN.
module tb_cache_arbiter;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  cache_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

  cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".m_read"},  256'(bus.m_read),  256'(0));
    chk({tag, ".m_write"}, 256'(bus.m_write), 256'(0));
    chk({tag, ".i_resp"},  256'(bus.i_resp),  256'(0));
    chk({tag, ".d_resp"},  256'(bus.d_resp),  256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] line_a5, wd0, wd1;
    logic         exp_d;
    line_a5 = {32{8'hA5}};
    wd0     = {8{32'h1234_5678}};
    wd1     = {8{32'hDEAD_BEEF}};

    rst = 1'b1;
    bus.i_read = 0; bus.i_addr = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_rdata = '0; bus.m_resp = 0;
    cyc(); cyc();

    // reset state
    chk_idle("rst");
    chk("rst.m_addr",  256'(bus.m_addr), 256'(0));
    chk("rst.m_wdata", bus.m_wdata, 256'(0));
    rst = 1'b0;
    cyc();

    // single I fill, memory answers in cycle 5
    bus.i_read = 1; bus.i_addr = 32'h0000_0060;
    cyc();
    for (int c = 1; c <= 4; c++) begin
      chk("ifill.m_read", 256'(bus.m_read), 256'(1));
      chk("ifill.m_addr", 256'(bus.m_addr), 256'(32'h60));
      chk("ifill.i_resp", 256'(bus.i_resp), 256'(0));
      cyc();
    end
    bus.m_resp = 1; bus.m_rdata = line_a5;
    #1;
    chk("ifill.c5.m_read", 256'(bus.m_read), 256'(1));
    chk("ifill.c5.i_resp", 256'(bus.i_resp), 256'(1));
    chk("ifill.c5.d_resp", 256'(bus.d_resp), 256'(0));
    chk("ifill.c5.i_rdata", bus.i_rdata, line_a5);
    bus.i_read = 0;
    cyc();
    bus.m_resp = 0;
    #1;
    chk_idle("ifill.c6");

    // D writeback with address/data churn after the grant
    bus.d_write = 1; bus.d_addr = 32'h100; bus.d_wdata = wd0;
    cyc();
    bus.d_addr = 32'h200; bus.d_wdata = wd1;
    for (int c = 1; c <= 2; c++) begin
      #1;
      chk("dwb.m_write", 256'(bus.m_write), 256'(1));
      chk("dwb.m_read",  256'(bus.m_read),  256'(0));
      chk("dwb.m_addr",  256'(bus.m_addr),  256'(32'h100));
      chk("dwb.m_wdata", bus.m_wdata, wd0);
      chk("dwb.d_resp",  256'(bus.d_resp),  256'(0));
      cyc();
    end
    bus.m_resp = 1; bus.m_rdata = wd1;
    #1;
    chk("dwb.resp.d_resp", 256'(bus.d_resp), 256'(1));
    chk("dwb.resp.i_resp", 256'(bus.i_resp), 256'(0));
    chk("dwb.resp.d_rdata", bus.d_rdata, wd1);
    bus.d_write = 0;
    cyc();
    bus.m_resp = 0;
    #1;
    chk_idle("dwb.idle");

    // illegal read+write: write wins
    bus.d_read = 1; bus.d_write = 1; bus.d_addr = 32'h180; bus.d_wdata = wd1;
    cyc();
    chk("ill.m_write", 256'(bus.m_write), 256'(1));
    chk("ill.m_read",  256'(bus.m_read),  256'(0));
    chk("ill.m_addr",  256'(bus.m_addr),  256'(32'h180));
    bus.m_resp = 1;
    #1;
    chk("ill.d_resp", 256'(bus.d_resp), 256'(1));
    bus.d_read = 0; bus.d_write = 0;
    cyc();
    bus.m_resp = 0;
    #1;
    chk_idle("ill.idle");

    // ties from reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.i_read = 1; bus.i_addr = 32'h40;
    bus.d_read = 1; bus.d_addr = 32'h80;
    cyc();
    for (int k = 0; k < 4; k++) begin
`ifdef CACHE_ARBITER_RR_EN
      exp_d = (k % 2) == 1;
`else
      exp_d = 1'b1;
`endif
      #1;
      chk($sformatf("tie%0d.m_read", k), 256'(bus.m_read), 256'(1));
      chk($sformatf("tie%0d.m_addr", k), 256'(bus.m_addr),
          256'(exp_d ? 32'h80 : 32'h40));
      bus.m_resp = 1;
      #1;
      chk($sformatf("tie%0d.d_resp", k), 256'(bus.d_resp), 256'(exp_d));
      chk($sformatf("tie%0d.i_resp", k), 256'(bus.i_resp), 256'(!exp_d));
      cyc();
      bus.m_resp = 0;
      #1;
      chk_idle($sformatf("tie%0d.idle", k));
      cyc();
    end
    bus.m_resp = 1;
    #1;
    bus.i_read = 0; bus.d_read = 0;
    cyc();
    bus.m_resp = 0;
    #1;
    chk_idle("tie.end");
    cyc();

    // reset in cycle 3 of SERVE_I, stale m_resp in cycle 5
    bus.i_read = 1; bus.i_addr = 32'hC0;
    cyc(); cyc(); cyc();
    chk("rmid.c3.m_read", 256'(bus.m_read), 256'(1));
    rst = 1'b1;
    cyc();
    rst = 1'b0; bus.i_read = 0;
    #1;
    chk_idle("rmid.c4");
    chk("rmid.c4.m_addr", 256'(bus.m_addr), 256'(0));
    cyc();
    bus.m_resp = 1;
    #1;
    chk_idle("rmid.c5");
    cyc();
    bus.m_resp = 0;
    bus.d_read = 1; bus.d_addr = 32'h140;
    cyc();
    #1;
    chk("rmid.d.m_read",  256'(bus.m_read),  256'(1));
    chk("rmid.d.m_write", 256'(bus.m_write), 256'(0));
    chk("rmid.d.m_addr",  256'(bus.m_addr),  256'(32'h140));
    bus.m_resp = 1;
    #1;
    chk("rmid.d.d_resp", 256'(bus.d_resp), 256'(1));
    chk("rmid.d.i_resp", 256'(bus.i_resp), 256'(0));
    bus.d_read = 0;
    cyc();
    bus.m_resp = 0;
    #1;
    chk_idle("rmid.end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
